stack_arbiter: RTL and testbench

Shares one external LIFO stack (push/pop/data_in/data_out, depth 2**SIZE) between two requesters. Each requester issues push or pop over a valid/ready handshake. The arbiter grants round-robin, sequences the stack strobes, and tracks occupancy itself. Illegal operations (push-when-full, pop-when-empty) are blocked and reported per requester, so the stack never sees them.

---
 rtl/stack_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_stack_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_arbiter.sv
// stack_arbiter: lets two requesters share one external LIFO stack.
// Operations are granted round-robin and run one at a time
// (IDLE -> ISSUE -> RESP). The arbiter keeps its own occupancy count, so it
// can drop push-when-full and pop-when-empty before the stack sees them.
// A dropped operation is reported to the requester with an error flag.
//
// state  | meaning
// IDLE   | arbitrate, assert winner's ready, latch winner/op/data
// ISSUE  | pulse stk_push or stk_pop (legal op) or set error flag
// RESP   | one-cycle rsp pulse to the latched requester
//
// Ports:
//   clk, reset          system clock; synchronous active-high reset
//   reqX_valid/push/data  requester X operation (push=1, pop=0)
//   reqX_ready          requester X operation accepted this cycle
//   rspX_valid/err/data   response pulse, error flag, popped data
//   stk_push/pop/data_in  strobes and write data to the stack
//   stk_data_out        top-of-stack value from the stack
//   count, full, empty  occupancy tracked by the arbiter
module stack_arbiter #(
  parameter int WIDTH = 18,
  parameter int SIZE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req0_push,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  output logic             rsp0_valid,
  output logic             rsp0_err,
  output logic [WIDTH-1:0] rsp0_data,
  input  logic             req1_valid,
  input  logic             req1_push,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             rsp1_valid,
  output logic             rsp1_err,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_data_in,
  input  logic [WIDTH-1:0] stk_data_out,
  output logic [SIZE:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int            DEPTH_I = 1 << SIZE;
  localparam logic [SIZE:0] DEPTH   = (SIZE+1)'(DEPTH_I);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               win_q, win_d;
  logic               push_q, push_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   rdata_q, rdata_d;
  logic [SIZE:0]      count_q, count_d;
  logic               prio_q, prio_d;
  logic               gnt1;

  assign count = count_q;
  assign full  = (count_q == DEPTH);
  assign empty = (count_q == '0);

  // requester 1 wins when it is the only one valid, or both are valid and
  // the pointer favours it
  assign gnt1 = req1_valid & (~req0_valid | prio_q);

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    push_d      = push_q;
    data_d      = data_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    count_d     = count_q;
    prio_d      = prio_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp0_valid  = 1'b0;
    rsp0_err    = 1'b0;
    rsp0_data   = '0;
    rsp1_valid  = 1'b0;
    rsp1_err    = 1'b0;
    rsp1_data   = '0;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_data_in = '0;

    case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          req0_ready = ~gnt1;
          req1_ready = gnt1;
          win_d      = gnt1;
          push_d     = gnt1 ? req1_push : req0_push;
          data_d     = gnt1 ? req1_data : req0_data;
          prio_d     = ~gnt1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_RESP;
        err_d   = 1'b0;
        rdata_d = '0;
        if (push_q) begin
          if (!full) begin
            stk_push    = 1'b1;
            stk_data_in = data_q;
            count_d     = count_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          if (!empty) begin
            stk_pop = 1'b1;
            rdata_d = stk_data_out;
            count_d = count_q - 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (win_q) begin
          rsp1_valid = 1'b1;
          rsp1_err   = err_q;
          rsp1_data  = rdata_q;
        end else begin
          rsp0_valid = 1'b1;
          rsp0_err   = err_q;
          rsp0_data  = rdata_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Reset is synchronous, so the registers still show the old state during
    // the reset cycle; mask every outward action so an interrupted operation
    // never reaches the stack or the requester.
    if (reset) begin
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      rsp0_valid  = 1'b0;
      rsp0_err    = 1'b0;
      rsp0_data   = '0;
      rsp1_valid  = 1'b0;
      rsp1_err    = 1'b0;
      rsp1_data   = '0;
      stk_push    = 1'b0;
      stk_pop     = 1'b0;
      stk_data_in = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      win_q   <= 1'b0;
      push_q  <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      count_q <= '0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      push_q  <= push_d;
      data_q  <= data_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      count_q <= count_d;
      prio_q  <= prio_d;
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
module tb_stack_arbiter;

  localparam int W     = 18;
  localparam int SZ    = 1;
  localparam int DEPTH = 1 << SZ;

  logic          clk;
  logic          reset;
  logic          req0_valid, req0_push, req0_ready, rsp0_valid, rsp0_err;
  logic [W-1:0]  req0_data, rsp0_data;
  logic          req1_valid, req1_push, req1_ready, rsp1_valid, rsp1_err;
  logic [W-1:0]  req1_data, rsp1_data;
  logic          stk_push, stk_pop;
  logic [W-1:0]  stk_data_in, stk_data_out;
  logic [SZ:0]   count;
  logic          full, empty;

  stack_arbiter #(.WIDTH(W), .SIZE(SZ)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_push(req0_push), .req0_data(req0_data),
    .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_err(rsp0_err),
    .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_push(req1_push), .req1_data(req1_data),
    .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_err(rsp1_err),
    .rsp1_data(rsp1_data),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_data_in(stk_data_in),
    .stk_data_out(stk_data_out),
    .count(count), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting (cycle %0d)", nm, cyc);
  endtask

  function automatic int at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD;
  endfunction

  // external stack environment
  logic [W-1:0] smem [0:DEPTH-1];
  int           sp;
  always @(posedge clk) begin
    if (reset) sp <= 0;
    else if (stk_push && sp < DEPTH) begin
      smem[sp] <= stk_data_in;
      sp       <= sp + 1;
    end else if (stk_pop && sp > 0) sp <= sp - 1;
  end
  assign stk_data_out = (sp > 0) ? smem[sp-1] : '0;

  // requester drivers: each queue holds pending ops, held until accepted
  typedef struct { bit push; logic [W-1:0] data; } op_t;
  op_t q0[$];
  op_t q1[$];
  bit  hs0, hs1;

  initial begin
    req0_valid = 0; req0_push = 0; req0_data = '0;
    req1_valid = 0; req1_push = 0; req1_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (hs0 && q0.size() > 0) q0.delete(0);
      if (hs1 && q1.size() > 0) q1.delete(0);
      if (q0.size() > 0) begin
        req0_valid = 1; req0_push = q0[0].push; req0_data = q0[0].data;
      end else begin
        req0_valid = 0; req0_push = 0; req0_data = '0;
      end
      if (q1.size() > 0) begin
        req1_valid = 1; req1_push = q1[0].push; req1_data = q1[0].data;
      end else begin
        req1_valid = 0; req1_push = 0; req1_data = '0;
      end
    end
  end

  // observation logs
  int g_who[$], g_cyc[$];
  int r_who[$], r_err[$], r_data[$], r_cyc[$];
  int n_spush = 0, n_spop = 0, both_high = 0;

  // transaction-level model: an accepted op is resolved immediately against
  // a queue stack; its strobe is expected one cycle later, its response two
  int          age = -1;
  bit          ptr = 0;
  bit          started = 0;
  logic [W-1:0] mstk[$];
  bit          p_who, p_push, p_err;
  logic [W-1:0] p_wdata, p_rdata;
  int          p_cnt;

  always @(negedge clk) begin
    logic e_r0, e_r1, e_sp, e_spop, e_v0, e_v1, e_e0, e_e1;
    logic [W-1:0] e_din, e_d0, e_d1;
    int e_cnt;
    bit anyv, win;

    hs0 = req0_valid && req0_ready;
    hs1 = req1_valid && req1_ready;
    if (stk_push) n_spush++;
    if (stk_pop) n_spop++;
    if (stk_push && stk_pop) both_high++;
    if (req0_ready) begin g_who.push_back(0); g_cyc.push_back(cyc); end
    if (req1_ready) begin g_who.push_back(1); g_cyc.push_back(cyc); end
    if (rsp0_valid) begin
      r_who.push_back(0); r_err.push_back(int'(rsp0_err));
      r_data.push_back(int'(rsp0_data)); r_cyc.push_back(cyc);
    end
    if (rsp1_valid) begin
      r_who.push_back(1); r_err.push_back(int'(rsp1_err));
      r_data.push_back(int'(rsp1_data)); r_cyc.push_back(cyc);
    end

    {e_r0, e_r1, e_sp, e_spop, e_v0, e_v1, e_e0, e_e1} = '0;
    e_din = '0; e_d0 = '0; e_d1 = '0;
    e_cnt = mstk.size();
    anyv = req0_valid || req1_valid;
    win  = (req0_valid && req1_valid) ? ptr : req1_valid;

    if (!reset && started) begin
      if (age < 0 && anyv) begin
        if (win) e_r1 = 1; else e_r0 = 1;
      end
      if (age == 1) begin
        e_cnt = p_cnt;
        if (!p_err) begin
          if (p_push) begin e_sp = 1; e_din = p_wdata; end
          else e_spop = 1;
        end
      end
      if (age == 2) begin
        if (p_who) begin e_v1 = 1; e_e1 = p_err; e_d1 = p_rdata; end
        else begin e_v0 = 1; e_e0 = p_err; e_d0 = p_rdata; end
      end
    end

    if (reset || started) begin
      chk("req0_ready", req0_ready, e_r0);
      chk("req1_ready", req1_ready, e_r1);
      chk("stk_push", stk_push, e_sp);
      chk("stk_pop", stk_pop, e_spop);
      chk("stk_data_in", stk_data_in, e_din);
      chk("rsp0_valid", rsp0_valid, e_v0);
      chk("rsp0_err", rsp0_err, e_e0);
      chk("rsp0_data", rsp0_data, e_d0);
      chk("rsp1_valid", rsp1_valid, e_v1);
      chk("rsp1_err", rsp1_err, e_e1);
      chk("rsp1_data", rsp1_data, e_d1);
    end
    if (!reset && started) begin
      chk("count", count, e_cnt);
      chk("full", full, e_cnt == DEPTH);
      chk("empty", empty, e_cnt == 0);
    end

    if (reset) begin
      age = -1; ptr = 0; mstk.delete(); started = 1;
    end else if (started) begin
      if (age == 2) age = -1;
      else if (age >= 0) age++;
      else if (anyv) begin
        age     = 1;
        p_who   = win;
        ptr     = !win;
        p_push  = win ? req1_push : req0_push;
        p_wdata = win ? req1_data : req0_data;
        p_cnt   = mstk.size();
        p_rdata = '0;
        p_err   = 0;
        if (p_push) begin
          if (mstk.size() >= DEPTH) p_err = 1;
          else mstk.push_back(p_wdata);
        end else begin
          if (mstk.size() == 0) p_err = 1;
          else p_rdata = mstk.pop_back();
        end
      end
    end
  end

  task automatic clear_logs();
    g_who.delete(); g_cyc.delete();
    r_who.delete(); r_err.delete(); r_data.delete(); r_cyc.delete();
  endtask

  task automatic drain(input string nm);
    int i;
    for (i = 0; i < 400 && (q0.size() > 0 || q1.size() > 0); i++) @(negedge clk);
    if (q0.size() > 0 || q1.size() > 0) timeout_fail(nm);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int ps, pp, rc;
    bit seen;
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);

    // fill to full, then an illegal push
    clear_logs(); ps = n_spush;
    q0.push_back('{1'b1, 18'h15555});
    q0.push_back('{1'b1, 18'h2AAAA});
    q0.push_back('{1'b1, 18'h04444});
    drain("fill_drain");
    chk("fill_npush", n_spush - ps, 2);
    chk("fill_nrsp", r_who.size(), 3);
    chk("fill_err0", at(r_err, 0), 0);
    chk("fill_err1", at(r_err, 1), 0);
    chk("fill_err2", at(r_err, 2), 1);
    chk("fill_data2", at(r_data, 2), 0);
    chk("fill_count", count, 2);
    chk("fill_full", full, 1);

    // empty it via req0, then req1 pops on empty
    clear_logs();
    q0.push_back('{1'b0, '0});
    q0.push_back('{1'b0, '0});
    drain("empty_drain");
    chk("pop_data0", at(r_data, 0), 32'h2AAAA);
    chk("pop_data1", at(r_data, 1), 32'h15555);
    clear_logs(); pp = n_spop;
    q1.push_back('{1'b0, '0});
    drain("popempty_drain");
    chk("popempty_who", at(r_who, 0), 1);
    chk("popempty_err", at(r_err, 0), 1);
    chk("popempty_data", at(r_data, 0), 0);
    chk("popempty_nopop", n_spop - pp, 0);
    chk("popempty_empty", empty, 1);

    // simultaneous pushes from empty
    clear_logs();
    q0.push_back('{1'b1, 18'h11111});
    q1.push_back('{1'b1, 18'h22222});
    drain("contend_drain");
    chk("contend_g0", at(g_who, 0), 0);
    chk("contend_g1", at(g_who, 1), 1);
    chk("contend_gap", at(g_cyc, 1) - at(g_cyc, 0), 3);
    clear_logs();
    q1.push_back('{1'b0, '0});
    q1.push_back('{1'b0, '0});
    drain("req1pop_drain");
    chk("req1pop_d0", at(r_data, 0), 32'h22222);
    chk("req1pop_d1", at(r_data, 1), 32'h11111);
    chk("req1pop_count", count, 0);

    // reset while a push is in ISSUE
    clear_logs();
    q0.push_back('{1'b1, 18'h0ABCD});
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = req0_ready;
    end
    if (!seen) timeout_fail("midrst_grant");
    @(posedge clk);
    #1 reset = 1;
    ps = n_spush; rc = r_who.size();
    @(posedge clk);
    #1 reset = 0;
    repeat (3) @(negedge clk);
    chk("midrst_nopush", n_spush - ps, 0);
    chk("midrst_norsp", r_who.size() - rc, 0);
    chk("midrst_count", count, 0);
    clear_logs();
    q0.push_back('{1'b1, 18'h00001});
    q1.push_back('{1'b1, 18'h00002});
    drain("midrst_drain");
    chk("midrst_g0", at(g_who, 0), 0);
    chk("midrst_g1", at(g_who, 1), 1);

    // continuous contention, stack holds [1,2]
    clear_logs();
    q0.push_back('{1'b0, '0});
    q0.push_back('{1'b1, 18'h0A0A0});
    q0.push_back('{1'b0, '0});
    q1.push_back('{1'b0, '0});
    q1.push_back('{1'b1, 18'h0B0B0});
    q1.push_back('{1'b0, '0});
    drain("rr_drain");
    chk("rr_ngrant", g_who.size(), 6);
    chk("rr_nrsp", r_who.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk("rr_grant", at(g_who, i), i % 2);
      chk("rr_rspwho", at(r_who, i), i % 2);
      chk("rr_latency", at(r_cyc, i) - at(g_cyc, i), 2);
      chk("rr_err", at(r_err, i), 0);
    end
    chk("rr_d0", at(r_data, 0), 32'h00002);
    chk("rr_d1", at(r_data, 1), 32'h00001);
    chk("rr_d2", at(r_data, 2), 0);
    chk("rr_d3", at(r_data, 3), 0);
    chk("rr_d4", at(r_data, 4), 32'h0B0B0);
    chk("rr_d5", at(r_data, 5), 32'h0A0A0);
    chk("both_strobes", both_high, 0);
    chk("rr_count", count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected below 20000", cyc);
    $fatal(1, "watchdog");
  end

endmodule
